// File: rtl/verif_comp_pkg.sv
// Shared types and helpers for the verif_comp operand/sum pipeline.
package verif_comp_pkg;

  localparam int DATA_W_DEF = 8;

  typedef logic [DATA_W_DEF-1:0] operand_t;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } fsm_state_t;

  // A sum of group values of data_w bits each needs $clog2(group) extra bits.
  function automatic int sum_width(input int data_w, input int group);
    return data_w + $clog2(group);
  endfunction

endpackage

// File: rtl/verif_comp_b_if.sv
// Operand input stream (a_*) and group-sum output stream (b_*) of verif_comp_b.
// Both streams: a beat transfers on a posedge where valid & ready are both high;
// valid and payload stay stable until that transfer, and ready may not depend on valid.
interface verif_comp_b_if
  import verif_comp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int GROUP  = 4
);
  localparam int SUM_W = sum_width(DATA_W, GROUP);

  logic              a_valid;
  logic              a_ready;
  logic [DATA_W-1:0] a_operand;
  logic              b_valid;
  logic              b_ready;
  logic [SUM_W-1:0]  b_sum;

  modport master (
    output a_valid, a_operand, b_ready,
    input  a_ready, b_valid, b_sum
  );

  modport slave (
    input  a_valid, a_operand, b_ready,
    output a_ready, b_valid, b_sum
  );

endinterface

// File: rtl/verif_sync_fifo.sv
// Small synchronous FIFO with registered storage and an occupancy count.
module verif_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/verif_comp_b.sv
// Buffers operands, sums each group of GROUP of them and offers the sum downstream;
// also counts every accepted operand modulo 2^16.
module verif_comp_b
  import verif_comp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int GROUP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  verif_comp_b_if.slave     bus,
  output logic [15:0]       op_count,
  output fsm_state_t        dbg_state
);

  localparam int SUM_W = sum_width(DATA_W, GROUP);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int GRP_W = $clog2(GROUP + 1);

  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic [CNT_W-1:0]  fifo_count, fifo_count_next;

  fsm_state_t        state_q, state_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [SUM_W-1:0]  b_sum_q, b_sum_d;
  logic [GRP_W-1:0]  cnt_q, cnt_d;
  logic              b_valid_q, b_valid_d;
  logic              a_ready_q, a_ready_d;
  logic [15:0]       op_count_q, op_count_d;

  assign push = bus.a_valid & a_ready_q & ~fifo_full;
  assign pop  = (state_q == ACCUM) & ~fifo_empty;

  verif_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.a_operand),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Ready is registered from next-cycle occupancy, so a push can never land on a full FIFO.
  always_comb begin
    fifo_count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    a_ready_d       = (fifo_count_next != CNT_W'(DEPTH));
    op_count_d      = op_count_q + 16'(push);
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    b_valid_d = b_valid_q;
    b_sum_d   = b_sum_q;
    case (state_q)
      ACCUM: begin
        if (pop) begin
          acc_d = acc_q + SUM_W'(fifo_dout);
          cnt_d = cnt_q + GRP_W'(1);
          if (cnt_q == GRP_W'(GROUP - 1)) begin
            b_sum_d   = acc_q + SUM_W'(fifo_dout);
            b_valid_d = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        // b_sum keeps its value after the handshake; only valid drops.
        if (bus.b_ready) begin
          b_valid_d = 1'b0;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      b_valid_q  <= 1'b0;
      b_sum_q    <= '0;
      a_ready_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      b_valid_q  <= b_valid_d;
      b_sum_q    <= b_sum_d;
      a_ready_q  <= a_ready_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.a_ready = a_ready_q;
  assign bus.b_valid = b_valid_q;
  assign bus.b_sum   = b_sum_q;
  assign op_count    = op_count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_verif_comp_b.sv
// Bench for verif_comp_b: directed vectors, multi-cycle corner sequences and random
// traffic checked against a queue-based group-sum model.
module tb_verif_comp_b;
  import verif_comp_pkg::*;

  localparam int GROUP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] op_count;
  fsm_state_t  dbg_state;

  verif_comp_b_if #(.DATA_W(8), .GROUP(GROUP)) bus ();

  verif_comp_b #(.DATA_W(8), .DEPTH(4), .GROUP(GROUP)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .op_count  (op_count),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_bh     = 0;
  logic [9:0]  exp_q[$];
  logic [7:0]  grp[$];
  logic [15:0] m_op_count = '0;
  logic        hold_prev  = 1'b0;
  logic [9:0]  sum_prev   = '0;
  logic        rand_bready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 20)
        $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    grp.delete();
    m_op_count = '0;
    hold_prev  = 1'b0;
  endtask

  // Sampled mid-cycle: the handshakes seen here complete on the next posedge.
  always @(negedge clk) begin
    int s;
    if (!rst) begin
      check("op_count", op_count, m_op_count);
      check("hold_iff_bvalid", dbg_state == HOLD, bus.b_valid);
      if (hold_prev) begin
        check("hold_bvalid", bus.b_valid, 1);
        check("hold_bsum", bus.b_sum, sum_prev);
      end
      if (bus.b_valid) begin
        check("bvalid_expected", exp_q.size() != 0, 1);
        if (bus.b_ready && exp_q.size() != 0) begin
          check("sb_sum", bus.b_sum, exp_q.pop_front());
          n_bh++;
        end
      end
      hold_prev = bus.b_valid & ~bus.b_ready;
      sum_prev  = bus.b_sum;
      if (bus.a_valid && bus.a_ready) begin
        grp.push_back(bus.a_operand);
        m_op_count = m_op_count + 16'd1;
        if (grp.size() == GROUP) begin
          s = 0;
          foreach (grp[i]) s += int'(grp[i]);
          exp_q.push_back(10'(s));
          grp.delete();
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_bready) begin
      #1;
      bus.b_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_a_ready", bus.a_ready, 0);
    check("rst_b_valid", bus.b_valid, 0);
    check("rst_b_sum", bus.b_sum, 0);
    check("rst_op_count", op_count, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    check("rst_release_a_ready_low", bus.a_ready, 0);
    @(posedge clk);
    #1;
    check("rst_first_edge_a_ready", bus.a_ready, 1);
  endtask

  // Called at posedge+1; a_ready is stable until the next posedge.
  task automatic send(input logic [7:0] op);
    logic rdy;
    int   t;
    bus.a_valid   = 1'b1;
    bus.a_operand = op;
    rdy = 1'b0;
    t   = 0;
    while (t < 200) begin
      rdy = bus.a_ready;
      @(posedge clk);
      #1;
      t++;
      if (rdy) break;
    end
    check("send_accept", rdy, 1);
    bus.a_valid = 1'b0;
  endtask

  task automatic wait_bvalid(input string name);
    for (int t = 0; t < 30; t++) begin
      if (bus.b_valid) break;
      @(posedge clk);
      #1;
    end
    check(name, bus.b_valid, 1);
  endtask

  task automatic wait_drain(input string name);
    for (int t = 0; t < 200; t++) begin
      if (exp_q.size() == 0 && !bus.b_valid) break;
      @(posedge clk);
      #1;
    end
    check(name, exp_q.size(), 0);
    check({name, "_partial"}, grp.size(), 0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    operand_t   op [4];
    logic [9:0] exp_sum;
  } vec_t;

  vec_t vecs [5];

  // ---------------- main sequence ----------------
  initial begin
    int bh0;

    vecs[0].op = '{8'd1, 8'd2, 8'd3, 8'd4};        vecs[0].exp_sum = 10'd10;
    vecs[1].op = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};    vecs[1].exp_sum = 10'h3FC;
    vecs[2].op = '{8'h00, 8'h00, 8'h00, 8'h00};    vecs[2].exp_sum = 10'h000;
    vecs[3].op = '{8'h80, 8'h80, 8'h80, 8'h80};    vecs[3].exp_sum = 10'h200;
    vecs[4].op = '{8'h01, 8'h00, 8'h00, 8'hFE};    vecs[4].exp_sum = 10'h0FF;

    bus.a_valid   = 1'b0;
    bus.a_operand = '0;
    bus.b_ready   = 1'b1;

    do_reset();

    // Latency and single-cycle result pulse.
    send(8'd1); send(8'd2); send(8'd3); send(8'd4);
    check("lat_k1_bvalid", bus.b_valid, 0);
    @(posedge clk); #1;
    check("lat_k2_bvalid", bus.b_valid, 1);
    check("lat_k2_sum", bus.b_sum, 10);
    @(posedge clk); #1;
    check("lat_pulse_end", bus.b_valid, 0);
    check("lat_sum_held", bus.b_sum, 10);
    check("lat_op_count", op_count, 4);

    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < 4; j++) send(vecs[v].op[j]);
      wait_bvalid("vec_bvalid");
      check("vec_sum", bus.b_sum, vecs[v].exp_sum);
      @(posedge clk); #1;
      check("vec_pulse_end", bus.b_valid, 0);
    end

    // Backpressure: first sum held while the FIFO fills.
    do_reset();
    bus.b_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i));
    check("bp_a_ready_full", bus.a_ready, 0);
    check("bp_bvalid", bus.b_valid, 1);
    check("bp_sum", bus.b_sum, 10);
    check("bp_op_count", op_count, 8);
    bus.a_valid   = 1'b1;
    bus.a_operand = 8'd9;
    repeat (3) begin @(posedge clk); #1; end
    check("bp_still_blocked", bus.a_ready, 0);
    check("bp_sum_stable", bus.b_sum, 10);
    check("bp_op_count_stable", op_count, 8);
    bus.a_valid = 1'b0;
    bus.b_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_drop", bus.b_valid, 0);
    wait_bvalid("bp_second_bvalid");
    check("bp_second_sum", bus.b_sum, 26);
    wait_drain("bp_drain");
    check("bp_final_op_count", op_count, 8);

    // Reset mid-group discards the partial sum.
    do_reset();
    send(8'd7); send(8'd7);
    @(posedge clk); #1;
    do_reset();
    bh0 = n_bh;
    send(8'd1); send(8'd1); send(8'd1); send(8'd1);
    wait_bvalid("rg_bvalid");
    check("rg_sum", bus.b_sum, 4);
    repeat (6) begin @(posedge clk); #1; end
    check("rg_one_result", n_bh - bh0, 1);

    // Random traffic with random gaps and random downstream stalls.
    rand_bready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rand_bready = 1'b0;
    @(posedge clk); #1;
    bus.b_ready = 1'b1;
    wait_drain("rand_drain");

    // op_count wrap after 2^16 transfers.
    do_reset();
    bh0 = n_bh;
    for (int i = 0; i < 65536; i++) send(8'($urandom_range(0, 255)));
    wait_drain("wrap_drain");
    check("wrap_op_count", op_count, 0);
    check("wrap_results", n_bh - bh0, 16384);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    n_errors++;
    $display("FAIL watchdog: got time limit reached required completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
